// File: rtl/ysyx_25040111_axi_sram_pkg.sv
// Shared response codes, FSM states and address-range helper for the AXI SRAM.
// Optional stall injection: YSYX_25040111_AXI_SRAM_DELAY_EN (see top).
package ysyx_25040111_axi_sram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_BURST
  } r_state_t;

  function automatic logic out_of_range(
    input logic [31:0] addr,
    input logic [31:0] base,
    input int          aw_words
  );
    return (addr - base) >= (32'd4 << aw_words);
  endfunction

endpackage

// File: rtl/ysyx_25040111_axi_sram_if.sv
// AXI4 subset bus between the core's master port and the SRAM responder.
// Single fixed ID, INCR bursts of 32-bit words only.
interface ysyx_25040111_axi_sram_if;

  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  modport master (
    output awvalid, awaddr, awlen,
    output wvalid, wdata, wstrb, wlast,
    output bready,
    output arvalid, araddr, arlen,
    output rready,
    input  awready, wready, bvalid, bresp,
    input  arready, rvalid, rdata, rresp, rlast
  );

  modport slave (
    input  awvalid, awaddr, awlen,
    input  wvalid, wdata, wstrb, wlast,
    input  bready,
    input  arvalid, araddr, arlen,
    input  rready,
    output awready, wready, bvalid, bresp,
    output arready, rvalid, rdata, rresp, rlast
  );

endinterface

// File: rtl/ysyx_25040111_axi_sram_arr.sv
// 1W1R word array with byte-enable writes and a registered read port.
// A same-cycle write and read of one word returns the old word to the read.
module ysyx_25040111_axi_sram_arr #(
  parameter int AW = 14
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wstrb,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clock) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ysyx_25040111_axi_sram.sv
// AXI4 responder memory: independent read/write FSMs over one word array.
// Define YSYX_25040111_AXI_SRAM_DELAY_EN to inject LFSR-driven stalls.
module ysyx_25040111_axi_sram
  import ysyx_25040111_axi_sram_pkg::*;
#(
  parameter logic [31:0] BASE     = 32'h8000_0000,
  parameter int          AW_WORDS = 14,
  parameter int          RD_LAT   = 1
) (
  input logic                      clock,
  input logic                      reset,
  ysyx_25040111_axi_sram_if.slave  bus
);

  localparam logic [4:0] LAT = 5'(RD_LAT);

  logic go;

`ifdef YSYX_25040111_AXI_SRAM_DELAY_EN
  logic [15:0] lfsr;
  logic [1:0]  stall;

  // a stall run is capped at three cycles
  assign go = (lfsr[1:0] != 2'b00) || (stall == 2'd3);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr  <= 16'hACE1;
      stall <= 2'd0;
    end else begin
      lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      stall <= go ? 2'd0 : stall + 2'd1;
    end
  end
`else
  assign go = 1'b1;
`endif

  w_state_t    w_state;
  logic [31:0] waddr;
  logic [7:0]  wlen;
  logic [7:0]  wbeat;
  logic        werr;
  logic [1:0]  bresp_q;
  logic        aw_hs;
  logic        w_hs;
  logic        w_oor;
  logic        w_final;
  logic        w_bad;

  assign bus.awready = (w_state == W_IDLE) && go;
  assign bus.wready  = (w_state == W_DATA) && go;
  assign bus.bvalid  = (w_state == W_RESP);
  assign bus.bresp   = bresp_q;

  assign aw_hs   = bus.awvalid && bus.awready;
  assign w_hs    = bus.wvalid && bus.wready;
  assign w_oor   = out_of_range(waddr, BASE, AW_WORDS);
  assign w_final = (wbeat == wlen);
  assign w_bad   = w_oor || (bus.wlast != w_final);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_state <= W_IDLE;
      waddr   <= 32'h0;
      wlen    <= 8'h0;
      wbeat   <= 8'h0;
      werr    <= 1'b0;
      bresp_q <= RESP_OKAY;
    end else begin
      unique case (w_state)
        W_IDLE: if (aw_hs) begin
          waddr   <= bus.awaddr;
          wlen    <= bus.awlen;
          wbeat   <= 8'h0;
          werr    <= 1'b0;
          w_state <= W_DATA;
        end
        W_DATA: if (w_hs) begin
          waddr <= waddr + 32'd4;
          wbeat <= wbeat + 8'd1;
          werr  <= werr | w_bad;
          if (w_final) begin
            bresp_q <= (werr || w_bad) ? RESP_DECERR : RESP_OKAY;
            w_state <= W_RESP;
          end
        end
        W_RESP: if (bus.bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  r_state_t    r_state;
  logic [31:0] raddr;
  logic [7:0]  rlen;
  logic [7:0]  rbeat;
  logic [3:0]  wait_cnt;
  logic        rvalid_q;
  logic        rlast_q;
  logic [1:0]  rresp_q;
  logic        ar_hs;
  logic        r_hs;
  logic        wait_done;
  logic        f_en;
  logic [31:0] f_addr;
  logic [7:0]  f_len;
  logic [7:0]  f_beat;
  logic        f_oor;
  logic [31:0] arr_rdata;

  assign bus.arready = (r_state == R_IDLE) && go;
  assign bus.rvalid  = rvalid_q;
  assign bus.rresp   = rresp_q;
  assign bus.rlast   = rlast_q;
  assign bus.rdata   = (rvalid_q && rresp_q == RESP_OKAY) ? arr_rdata : 32'h0;

  assign ar_hs     = bus.arvalid && bus.arready;
  assign r_hs      = rvalid_q && bus.rready;
  assign wait_done = ({1'b0, wait_cnt} + 5'd2) >= LAT;
  assign f_oor     = out_of_range(f_addr, BASE, AW_WORDS);

  // Fetch is issued one cycle before a beat is presented.
  always_comb begin
    f_en   = 1'b0;
    f_addr = raddr;
    f_len  = rlen;
    f_beat = rbeat + 8'd1;
    unique case (r_state)
      R_IDLE: if (ar_hs && RD_LAT == 1) begin
        f_en   = 1'b1;
        f_addr = bus.araddr;
        f_len  = bus.arlen;
        f_beat = 8'h0;
      end
      R_WAIT: if (wait_done && go) begin
        f_en   = 1'b1;
        f_beat = 8'h0;
      end
      R_BURST: if (r_hs && !rlast_q) begin
        f_en   = 1'b1;
        f_addr = raddr + 32'd4;
      end
      default: f_en = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= R_IDLE;
      raddr    <= 32'h0;
      rlen     <= 8'h0;
      rbeat    <= 8'h0;
      wait_cnt <= 4'h0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rresp_q  <= RESP_OKAY;
    end else begin
      if (f_en) begin
        raddr    <= f_addr;
        rbeat    <= f_beat;
        rvalid_q <= 1'b1;
        rlast_q  <= (f_beat == f_len);
        rresp_q  <= f_oor ? RESP_DECERR : RESP_OKAY;
        r_state  <= R_BURST;
      end
      unique case (r_state)
        R_IDLE: if (ar_hs) begin
          rlen     <= bus.arlen;
          wait_cnt <= 4'h0;
          if (!f_en) begin
            raddr   <= bus.araddr;
            r_state <= R_WAIT;
          end
        end
        R_WAIT: if (!wait_done) wait_cnt <= wait_cnt + 4'd1;
        R_BURST: if (r_hs && rlast_q) begin
          rvalid_q <= 1'b0;
          rlast_q  <= 1'b0;
          r_state  <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  ysyx_25040111_axi_sram_arr #(
    .AW (AW_WORDS)
  ) u_arr (
    .clock (clock),
    .we    (w_hs && !w_oor),
    .waddr (AW_WORDS'((waddr - BASE) >> 2)),
    .wdata (bus.wdata),
    .wstrb (bus.wstrb),
    .re    (f_en),
    .raddr (AW_WORDS'((f_addr - BASE) >> 2)),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_ysyx_25040111_axi_sram.sv
// Randomized self-checking bench for the AXI SRAM responder.
// Expected data comes from a sparse word-map model of the memory.
module tb_ysyx_25040111_axi_sram;

  localparam logic [31:0] BASE     = 32'h8000_0000;
  localparam int          AW_WORDS = 14;
  localparam int          RD_LAT   = 1;
  localparam int          TMO      = 600;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] model [int];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic [31:0] rd [256];
  logic [1:0]  rr [256];
  logic        rl [256];

  ysyx_25040111_axi_sram_if bus ();

  ysyx_25040111_axi_sram #(
    .BASE     (BASE),
    .AW_WORDS (AW_WORDS),
    .RD_LAT   (RD_LAT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  function automatic bit m_oor(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE);
    return (off < 0) || (off >= (longint'(4) << AW_WORDS));
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (m_oor(a)) return 32'h0;
    if (!model.exists(m_idx(a))) return 32'hxxxx_xxxx;
    return model[m_idx(a)];
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    if (m_oor(a)) return;
    w = model.exists(m_idx(a)) ? model[m_idx(a)] : 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
    model[m_idx(a)] = w;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic timeout(input string what);
    checks++;
    errors++;
    $display("FAIL %s: timeout, no handshake within %0d cycles", what, TMO);
  endtask

  task automatic aw_put(input logic [31:0] a, input logic [7:0] l);
    bit rdy, ok;
    ok = 0;
    bus.awvalid = 1; bus.awaddr = a; bus.awlen = l;
    for (int i = 0; i < TMO; i++) begin
      rdy = bus.awready;
      tick();
      if (rdy) begin ok = 1; break; end
    end
    bus.awvalid = 0;
    if (!ok) timeout("aw");
  endtask

  task automatic w_put(input logic [31:0] d, input logic [3:0] s, input logic last);
    bit rdy, ok;
    ok = 0;
    bus.wvalid = 1; bus.wdata = d; bus.wstrb = s; bus.wlast = last;
    for (int i = 0; i < TMO; i++) begin
      rdy = bus.wready;
      tick();
      if (rdy) begin ok = 1; break; end
    end
    bus.wvalid = 0;
    if (!ok) timeout("w");
  endtask

  task automatic b_get(output logic [1:0] resp);
    bit ok;
    ok = 0; resp = 2'bxx;
    bus.bready = 1;
    for (int i = 0; i < TMO; i++) begin
      if (bus.bvalid) begin resp = bus.bresp; ok = 1; end
      tick();
      if (ok) break;
    end
    bus.bready = 0;
    if (!ok) timeout("b");
  endtask

  task automatic ar_put(input logic [31:0] a, input logic [7:0] l);
    bit rdy, ok;
    ok = 0;
    bus.arvalid = 1; bus.araddr = a; bus.arlen = l;
    for (int i = 0; i < TMO; i++) begin
      rdy = bus.arready;
      tick();
      if (rdy) begin ok = 1; break; end
    end
    bus.arvalid = 0;
    if (!ok) timeout("ar");
  endtask

  task automatic r_get(output logic [31:0] d, output logic [1:0] resp, output logic last);
    bit ok;
    ok = 0; d = 'x; resp = 'x; last = 'x;
    bus.rready = 1;
    for (int i = 0; i < TMO; i++) begin
      if (bus.rvalid) begin d = bus.rdata; resp = bus.rresp; last = bus.rlast; ok = 1; end
      tick();
      if (ok) break;
    end
    bus.rready = 0;
    if (!ok) timeout("r");
  endtask

  task automatic do_write(input logic [31:0] a, input int len, input int bad_last,
                          output logic [1:0] resp);
    aw_put(a, 8'(len));
    for (int i = 0; i <= len; i++) begin
      w_put(wd[i], ws[i], (i == len) ^ (i == bad_last));
      m_write(a + 32'(4 * i), wd[i], ws[i]);
    end
    b_get(resp);
  endtask

  task automatic do_read(input logic [31:0] a, input int len, input bit rand_rr);
    int beats;
    beats = 0;
    ar_put(a, 8'(len));
    for (int i = 0; i < TMO + 4 * len && beats <= len; i++) begin
      bus.rready = rand_rr ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.rvalid && bus.rready) begin
        rd[beats] = bus.rdata; rr[beats] = bus.rresp; rl[beats] = bus.rlast;
        beats++;
      end
      tick();
    end
    bus.rready = 0;
    if (beats <= len) timeout("read burst");
  endtask

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    return m_oor(a) ? 2'b11 : 2'b00;
  endfunction

  task automatic test_reset();
    reset = 0;
    repeat (3) tick();
    checks++;
    if ({bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, bus.rlast}
        !== 6'b110000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 110000",
        {bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, bus.rlast});
    end
    checks++;
    if ({bus.rdata, bus.bresp, bus.rresp} !== 36'h0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h bresp=%b rresp=%b want 0", bus.rdata, bus.bresp, bus.rresp);
    end
    reset = 1;
    tick();
  endtask

  task automatic test_single();
    logic [1:0]  resp;
    logic [31:0] d;
    logic        last;
    int          lat;
    wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
    do_write(32'h8000_0010, 0, -1, resp);
    checks++;
    if (resp !== 2'b00) begin errors++; $display("FAIL single_bresp: got %b want 00", resp); end
    ar_put(32'h8000_0010, 8'd0);
    lat = 1;
    while (!bus.rvalid && lat < 40) begin tick(); lat++; end
    checks++;
    if (lat != RD_LAT) begin errors++; $display("FAIL single_latency: got %0d want %0d", lat, RD_LAT); end
    r_get(d, resp, last);
    checks++;
    if ({d, resp, last} !== {32'hDEAD_BEEF, 2'b00, 1'b1}) begin
      errors++;
      $display("FAIL single_read: got %h/%b/%b want deadbeef/00/1", d, resp, last);
    end
  endtask

  task automatic test_byte_merge();
    logic [1:0] resp;
    wd[0] = 32'h1122_3344; ws[0] = 4'hF;
    do_write(32'h8000_0020, 0, -1, resp);
    wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0010;
    do_write(32'h8000_0020, 0, -1, resp);
    do_read(32'h8000_0020, 0, 0);
    checks++;
    if (rd[0] !== m_read(32'h8000_0020)) begin
      errors++;
      $display("FAIL byte_merge: got %h want %h", rd[0], m_read(32'h8000_0020));
    end
  endtask

  task automatic test_burst_backpressure();
    logic [1:0]  resp;
    logic [31:0] held;
    bit          stalled;
    int          beats;
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i); ws[i] = 4'hF; end
    do_write(32'h8000_0100, 3, -1, resp);
    ar_put(32'h8000_0100, 8'd3);
    beats = 0; stalled = 0; held = 0;
    for (int c = 0; c < 40 && beats < 4; c++) begin
      bus.rready = (c % 2 == 0);
      if (bus.rvalid && stalled) begin
        checks++;
        if (bus.rdata !== held) begin
          errors++;
          $display("FAIL bp_hold: got %h want %h", bus.rdata, held);
        end
      end
      stalled = 0;
      if (bus.rvalid && bus.rready) begin
        checks++;
        if ({bus.rdata, bus.rlast} !== {m_read(32'h8000_0100 + 32'(4 * beats)), 1'(beats == 3)}) begin
          errors++;
          $display("FAIL bp_beat%0d: got %h/%b want %h/%b", beats, bus.rdata, bus.rlast,
            m_read(32'h8000_0100 + 32'(4 * beats)), beats == 3);
        end
        beats++;
      end else if (bus.rvalid) begin
        held = bus.rdata; stalled = 1;
      end
      tick();
    end
    bus.rready = 0;
    if (beats < 4) timeout("bp burst");
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp;
    wd[0] = 32'hCAFE_0000; ws[0] = 4'hF;
    do_write(BASE, 0, -1, resp);
    do_read(32'h7FFF_FFFC, 0, 0);
    checks++;
    if ({rd[0], rr[0], rl[0]} !== {32'h0, 2'b11, 1'b1}) begin
      errors++;
      $display("FAIL oor_read: got %h/%b/%b want 0/11/1", rd[0], rr[0], rl[0]);
    end
    wd[0] = 32'h55; ws[0] = 4'hF;
    do_write(32'h8001_0000, 0, -1, resp);
    checks++;
    if (resp !== 2'b11) begin errors++; $display("FAIL oor_bresp: got %b want 11", resp); end
    do_read(BASE, 0, 0);
    checks++;
    if (rd[0] !== m_read(BASE)) begin
      errors++;
      $display("FAIL oor_unchanged: got %h want %h", rd[0], m_read(BASE));
    end
    wd[0] = 32'h0BAD_0001; wd[1] = 32'h0BAD_0002; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(32'h8000_0200, 1, 0, resp);
    checks++;
    if (resp !== 2'b11) begin errors++; $display("FAIL wlast_bresp: got %b want 11", resp); end
    do_read(32'h8000_0200, 1, 0);
    checks++;
    if ({rd[0], rd[1]} !== {m_read(32'h8000_0200), m_read(32'h8000_0204)}) begin
      errors++;
      $display("FAIL wlast_data: got %h %h want %h %h", rd[0], rd[1],
        m_read(32'h8000_0200), m_read(32'h8000_0204));
    end
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hF00D_0000 + 32'(i); ws[i] = 4'hF; end
    do_write(32'h8000_FFF8, 3, -1, resp);
    checks++;
    if (resp !== 2'b11) begin errors++; $display("FAIL top_bresp: got %b want 11", resp); end
    do_read(32'h8000_FFF8, 3, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({rd[i], rr[i]} !== {m_read(32'h8000_FFF8 + 32'(4 * i)), exp_resp(32'h8000_FFF8 + 32'(4 * i))}) begin
        errors++;
        $display("FAIL top_beat%0d: got %h/%b want %h/%b", i, rd[i], rr[i],
          m_read(32'h8000_FFF8 + 32'(4 * i)), exp_resp(32'h8000_FFF8 + 32'(4 * i)));
      end
    end
  endtask

  task automatic test_long_burst();
    logic [1:0] resp;
    int         bad;
    for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(32'h8000_1000, 255, -1, resp);
    checks++;
    if (resp !== 2'b00) begin errors++; $display("FAIL long_bresp: got %b want 00", resp); end
    do_read(32'h8000_1000, 255, 0);
    bad = 0;
    for (int i = 0; i < 256; i++)
      if ({rd[i], rr[i], rl[i]} !== {m_read(32'h8000_1000 + 32'(4 * i)), 2'b00, 1'(i == 255)}) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL long_read: %0d bad beats want 0", bad); end
  endtask

  task automatic test_reset_mid_burst();
    logic [1:0]  resp;
    logic [31:0] d;
    logic        last;
    for (int i = 0; i < 8; i++) begin wd[i] = 32'h3000_0000 + 32'(i); ws[i] = 4'hF; end
    do_write(32'h8000_0300, 7, -1, resp);
    ar_put(32'h8000_0300, 8'd7);
    r_get(d, resp, last);
    r_get(d, resp, last);
    reset = 0;
    tick();
    checks++;
    if ({bus.rvalid, bus.arready} !== 2'b01) begin
      errors++;
      $display("FAIL rst_mid: rvalid=%b arready=%b want 0/1", bus.rvalid, bus.arready);
    end
    reset = 1;
    bus.rready = 1;
    repeat (3) tick();
    bus.rready = 0;
    checks++;
    if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL rst_no_beats: rvalid=%b want 0", bus.rvalid); end
    do_read(32'h8000_0304, 0, 0);
    checks++;
    if ({rd[0], rr[0], rl[0]} !== {m_read(32'h8000_0304), 2'b00, 1'b1}) begin
      errors++;
      $display("FAIL rst_fresh: got %h/%b/%b want %h/00/1", rd[0], rr[0], rl[0], m_read(32'h8000_0304));
    end
  endtask

  task automatic test_collision();
    logic [1:0]  resp;
    logic [31:0] d, old;
    logic        last;
    bit          both;
    wd[0] = 32'h1234_5678; ws[0] = 4'hF;
    do_write(32'h8000_0400, 0, -1, resp);
    old = m_read(32'h8000_0400);
    aw_put(32'h8000_0400, 8'd0);
    bus.wvalid = 1; bus.wdata = 32'h0000_00FF; bus.wstrb = 4'hF; bus.wlast = 1;
    bus.arvalid = 1; bus.araddr = 32'h8000_0400; bus.arlen = 8'd0;
    both = 0;
    for (int i = 0; i < TMO && !both; i++) begin
      both = bus.wready && bus.arready;
      tick();
    end
    bus.wvalid = 0; bus.arvalid = 0;
    if (!both) timeout("collision");
    m_write(32'h8000_0400, 32'h0000_00FF, 4'hF);
    r_get(d, resp, last);
    checks++;
    if (d !== old) begin errors++; $display("FAIL collide_old: got %h want %h", d, old); end
    b_get(resp);
    do_read(32'h8000_0400, 0, 0);
    checks++;
    if (rd[0] !== 32'h0000_00FF) begin errors++; $display("FAIL collide_new: got %h want 000000ff", rd[0]); end
  endtask

  task automatic test_random();
    logic [1:0]  resp, want;
    logic [31:0] a;
    int          len, bad;
    for (int i = 0; i < 64; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(BASE, 63, -1, resp);
    for (int it = 0; it < 24; it++) begin
      if (it % 4 == 3) begin
        a = 32'h8000_FFF8 + 32'(4 * $urandom_range(0, 1));
        len = $urandom_range(0, 3);
      end else begin
        len = $urandom_range(0, 7);
        a = BASE + 32'(4 * $urandom_range(0, 63 - len));
      end
      want = 2'b00;
      for (int i = 0; i <= len; i++) begin
        wd[i] = $urandom; ws[i] = 4'($urandom);
        if (m_oor(a + 32'(4 * i))) want = 2'b11;
      end
      do_write(a, len, -1, resp);
      checks++;
      if (resp !== want) begin errors++; $display("FAIL rand_bresp it%0d: got %b want %b", it, resp, want); end
      do_read(a, len, 1);
      bad = 0;
      for (int i = 0; i <= len; i++)
        if ({rd[i], rr[i], rl[i]} !== {m_read(a + 32'(4 * i)), exp_resp(a + 32'(4 * i)), 1'(i == len)}) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL rand_read it%0d: %0d bad beats want 0", it, bad); end
    end
  endtask

  initial begin
    bus.awvalid = 0; bus.awaddr = 0; bus.awlen = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0;
    bus.bready = 0; bus.arvalid = 0; bus.araddr = 0; bus.arlen = 0;
    bus.rready = 0;
    test_reset();
    test_single();
    test_byte_merge();
    test_burst_backpressure();
    test_out_of_range();
    test_long_burst();
    test_reset_mid_burst();
    test_collision();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
